ram_arbiter2: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the single-port ram64x8 (64 x 8, sampled on negedge clk, registered dout).
- Accepts independent read/write requests from two masters over a req/gnt handshake.
- Drives the RAM's rw/addr/din, and returns read data with a one-cycle valid strobe to the owning requester.
- Sits between the RAM and the datapath masters, replacing a fixed-sequence FSM driver.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram64x8.sv | 23 ++
 rtl/ram_arb_rr.sv | 19 +
 rtl/ram_arbiter2.sv | 105 ++++++++++
 tb/tb_ram_arbiter2.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-requester ram64x8 arbiter.
package ram_arb_pkg;

  localparam int DEF_AW = 6;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram64x8.sv
// 64 x 8 single-port RAM: command sampled on negedge clk, registered read data.
module ram64x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rw,
  input  logic [5:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] mem [64];

  // NOTE: the storage array is never reset; only the output register is.
  always_ff @(negedge clk) begin
    if (rw) mem[addr] <= din;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)   dout <= '0;
    else if (!rw) dout <= mem[addr];
  end

endmodule

// File: rtl/ram_arb_rr.sv
// Combinational 2-way round-robin picker: on contention the requester other than `last` wins.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win_valid,
  output logic       win_idx
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    win_valid = |req;
    win_idx   = REQ0;
    if (&req)          win_idx = ~last;
    else if (req[REQ1]) win_idx = REQ1;
  end

endmodule

// File: rtl/ram_arbiter2.sv
// Round-robin arbiter and sequencer giving two masters read/write access to ram64x8.
module ram_arbiter2
  import ram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t        state;
  logic          last;
  logic          owner;
  logic [1:0]    req_vec;
  logic          win_valid;
  logic          win_idx;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  assign req_vec   = {req1, req0};
  assign win_we    = (win_idx == REQ1) ? we1    : we0;
  assign win_addr  = (win_idx == REQ1) ? addr1  : addr0;
  assign win_wdata = (win_idx == REQ1) ? wdata1 : wdata0;
  assign busy      = (state != IDLE);

  ram_arb_rr u_rr (
    .req       (req_vec),
    .last      (last),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // ram_rw doubles as the op type of the command in flight during ACCESS.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= REQ1;
      owner    <= REQ0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      ram_rw   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            ram_rw   <= win_we;
            ram_addr <= win_addr;
            ram_din  <= win_wdata;
            owner    <= win_idx;
            gnt0     <= (win_idx == REQ0);
            gnt1     <= (win_idx == REQ1);
            if (&req_vec) last <= win_idx;
            state    <= ACCESS;
          end else begin
            ram_rw <= 1'b0;
          end
        end
        ACCESS: begin
          if (ram_rw) begin
            ram_rw <= 1'b0;
            state  <= IDLE;
          end else begin
            rdata   <= ram_dout;
            rvalid0 <= (owner == REQ0);
            rvalid1 <= (owner == REQ1);
            state   <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter2.sv
// Self-checking bench for ram_arbiter2 + ram64x8 against a transaction-schedule reference model.
module tb_ram_arbiter2;
  import ram_arb_pkg::*;

  localparam int AW = DEF_AW;
  localparam int DW = DEF_DW;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          req   [2] = '{1'b0, 1'b0};
  logic          we    [2] = '{1'b0, 1'b0};
  logic [AW-1:0] addr  [2] = '{'0, '0};
  logic [DW-1:0] wdata [2] = '{'0, '0};

  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_rw;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter2 #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req[0]),
    .we0      (we[0]),
    .addr0    (addr[0]),
    .wdata0   (wdata[0]),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .req1     (req[1]),
    .we1      (we[1]),
    .addr1    (addr[1]),
    .wdata1   (wdata[1]),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .busy     (busy),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  ram64x8 u_ram (
    .clk   (clk),
    .rst_n (~reset),
    .rw    (ram_rw),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one op at a time; an op accepted at cycle k occupies
  // 2 cycles (write) or 3 cycles (read) before the next can be accepted.
  int            cyc       = 0;
  int            op_start  = -100;
  int            next_free = 0;
  bit            op_who    = 1'b0;
  bit            op_we_m   = 1'b0;
  bit            op_known  = 1'b0;
  bit            m_last    = 1'b1;
  bit            m_w;
  logic [AW-1:0] op_addr   = '0;
  logic [DW-1:0] op_din    = '0;
  logic [DW-1:0] op_rdata  = '0;
  logic [DW-1:0] m_rdata   = '0;
  bit            m_rdata_known = 1'b1;
  logic [DW-1:0] ref_mem   [64];
  bit            ref_known [64];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (op_we_m && cyc == op_start) ref_known[op_addr] = 1'b0;
      cyc           = 0;
      op_start      = -100;
      next_free     = 0;
      m_last        = 1'b1;
      m_rdata       = '0;
      m_rdata_known = 1'b1;
    end else begin
      cyc++;
      if (!op_we_m && cyc == op_start + 1) begin
        m_rdata       = op_rdata;
        m_rdata_known = op_known;
      end
      if (cyc >= next_free && (req[0] || req[1])) begin
        m_w = (req[0] && req[1]) ? !m_last : req[1];
        if (req[0] && req[1]) m_last = m_w;
        op_who   = m_w;
        op_start = cyc;
        op_we_m  = we[m_w];
        op_addr  = addr[m_w];
        op_din   = wdata[m_w];
        if (op_we_m) begin
          ref_mem[op_addr]   = op_din;
          ref_known[op_addr] = 1'b1;
          next_free          = cyc + 2;
        end else begin
          op_rdata  = ref_mem[op_addr];
          op_known  = ref_known[op_addr];
          next_free = cyc + 3;
        end
      end
    end
  end

  // Per-cycle comparison, plus event logs used by the directed scenarios.
  int m_d;
  int cnt_rw = 0;
  int cnt_g1 = 0;
  int order[$];

  always @(negedge clk) begin
    if (!reset) begin
      m_d = cyc - op_start;
      check("gnt0",    gnt0,    m_d == 0 && op_who == 1'b0);
      check("gnt1",    gnt1,    m_d == 0 && op_who == 1'b1);
      check("rvalid0", rvalid0, m_d == 1 && !op_we_m && op_who == 1'b0);
      check("rvalid1", rvalid1, m_d == 1 && !op_we_m && op_who == 1'b1);
      check("ram_rw",  ram_rw,  m_d == 0 && op_we_m);
      check("busy",    busy,    m_d == 0 || (m_d == 1 && !op_we_m));
      if (m_d == 0) begin
        check("ram_addr", ram_addr, op_addr);
        check("ram_din",  ram_din,  op_din);
      end
      if (m_rdata_known) check("rdata", rdata, m_rdata);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if (gnt1) cnt_g1++;
      if (ram_rw) cnt_rw++;
    end
  end

  function automatic logic gnt_of(input int i);
    return (i == 0) ? gnt0 : gnt1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one op, hold it until gnt is seen, release it the following cycle.
  task automatic do_op(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!gnt_of(i) && n < 40);
    check("gnt_seen", gnt_of(i), 1'b1);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic new_op(input int i);
    req[i]   = 1'b1;
    we[i]    = 1'($urandom_range(0, 1));
    addr[i]  = AW'(32 + $urandom_range(0, 7));
    wdata[i] = DW'($urandom);
  endtask

  int osz;
  int base;
  int n;
  bit held [2] = '{1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    check("rst_gnt0",   gnt0,     1'b0);
    check("rst_rvalid", rvalid0,  1'b0);
    check("rst_rdata",  rdata,    '0);
    check("rst_busy",   busy,     1'b0);
    check("rst_addr",   ram_addr, '0);
    @(negedge clk); #1 reset = 1'b0;
    idle(1);

    // Simultaneous first requests: requester 0 wins, then requester 1.
    osz = order.size();
    fork
      do_op(0, 1'b1, 6'd39, 8'd22);
      do_op(1, 1'b1, 6'd40, 8'd33);
    join
    idle(2);
    check("sim_count", order.size() - osz, 2);
    if (order.size() >= osz + 2) begin
      check("sim_first",  order[osz],     0);
      check("sim_second", order[osz + 1], 1);
    end
    do_op(0, 1'b0, 6'd39, 8'd0);
    check("rd39_valid", rvalid0, 1'b1);
    check("rd39_data",  rdata,   8'd22);
    idle(1);
    do_op(1, 1'b0, 6'd40, 8'd0);
    check("rd40_valid", rvalid1, 1'b1);
    check("rd40_data",  rdata,   8'd33);
    idle(1);

    // Write then read back through requester 0.
    do_op(0, 1'b1, 6'd35, 8'd11);
    idle(1);
    do_op(0, 1'b0, 6'd35, 8'd0);
    check("rb_rvalid0", rvalid0, 1'b1);
    check("rb_rvalid1", rvalid1, 1'b0);
    check("rb_rdata",   rdata,   8'd11);
    idle(1);

    // A single write pulses ram_rw exactly once.
    base = cnt_rw;
    do_op(0, 1'b1, 6'd20, 8'h77);
    idle(3);
    check("rw_pulses", cnt_rw - base, 1);
    do_op(1, 1'b0, 6'd20, 8'd0);
    check("rw_readback", rdata, 8'h77);
    idle(1);

    // Both requesters continuously requesting: grants alternate.
    osz = order.size();
    fork
      repeat (3) do_op(0, 1'b1, AW'($urandom_range(0, 15)), DW'($urandom));
      repeat (3) do_op(1, 1'b1, AW'($urandom_range(16, 31)), DW'($urandom));
    join
    idle(2);
    check("fair_count", order.size() - osz, 6);
    for (int i = 1; i < 6 && osz + i < order.size(); i++)
      check("fair_order", order[osz + i], order[osz] ^ (i % 2));

    // Withdraw: req1 raised while req0 is served, dropped before sampling.
    do_op(1, 1'b1, 6'd50, 8'h5A);
    idle(2);
    base = cnt_g1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'd35;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!gnt0 && n < 40);
    check("wd_gnt0", gnt0, 1'b1);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 6'd50; wdata[1] = 8'hEE;
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0;
    idle(4);
    check("wd_no_gnt1", cnt_g1 - base, 0);
    do_op(1, 1'b0, 6'd50, 8'd0);
    check("wd_rdata", rdata, 8'h5A);
    idle(1);

    // Reset during the ACCESS cycle of a requester-1 read.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'd35;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!gnt1 && n < 40);
    check("mr_gnt1", gnt1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mr_gnt0",    gnt0,     1'b0);
    check("mr_gnt1_0",  gnt1,     1'b0);
    check("mr_rvalid0", rvalid0,  1'b0);
    check("mr_rvalid1", rvalid1,  1'b0);
    check("mr_rdata",   rdata,    '0);
    check("mr_rw",      ram_rw,   1'b0);
    check("mr_addr",    ram_addr, '0);
    check("mr_din",     ram_din,  '0);
    check("mr_busy",    busy,     1'b0);
    req[1] = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    idle(1);
    osz = order.size();
    fork
      do_op(0, 1'b0, 6'd35, 8'd0);
      do_op(1, 1'b0, 6'd40, 8'd0);
    join
    idle(3);
    check("mr_count", order.size() - osz, 2);
    if (order.size() > osz) check("mr_first", order[osz], 0);

    // Randomized traffic with withdrawals, checked cycle by cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (held[i]) begin
          held[i] = 1'b0;
          if ($urandom_range(0, 2) != 0) new_op(i);
          else req[i] = 1'b0;
        end else if (gnt_of(i)) begin
          held[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 11) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          new_op(i);
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
